sub_divider: RTL and testbench
==============================

SUB_DIVIDER -- requirements
Module: sub_divider

Interface
REQ-001 Parameters: none; the datapath is fixed at 4 bits.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 dividend  in  4  unsigned dividend, captured when start is accepted.
REQ-006 divisor  in  4  unsigned divisor, captured when start is accepted.
REQ-007 sub_a  out  4  minuend to the downstream 4-bit subtractor (partial remainder register).
REQ-008 sub_b  out  4  subtrahend to the subtractor (captured divisor register).
REQ-009 sub_e  out  1  subtractor enable; high only in state SUB.
REQ-010 sub_d  in  4  difference returned by the subtractor (sub_a - sub_b, gated by sub_e).
REQ-011 sub_bout  in  1  borrow-out returned by the subtractor; 1 means sub_a < sub_b.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle pulse, high exactly while in state DONE.
REQ-014 quotient  out  4  registered result, held from DONE until the next accepted start.
REQ-015 remainder  out  4  registered result, held from DONE until the next accepted start.
REQ-016 div_by_zero  out  1  registered flag, valid with done, held like quotient.

Function
REQ-017 States: IDLE, SUB, DONE; sequential repeated-subtraction division using the external subtractor, one subtraction per SUB cycle.
REQ-018 IDLE with start=1 at a rising edge: R<=dividend, D<=divisor, Q<=0, div_by_zero<=0, next state SUB; start=0 stays in IDLE.
REQ-019 start in SUB or DONE is ignored; captured operands are never changed mid-operation.
REQ-020 sub_a=R and sub_b=D in all states; sub_e=1 in SUB, 0 otherwise; the subtractor path is combinational and consumed in the same cycle.
REQ-021 SUB, sub_bout=1: R and Q unchanged, next state DONE.
REQ-022 SUB, sub_bout=0 and Q=15: R and Q unchanged, next state DONE (iteration cap; Q never wraps).
REQ-023 SUB, sub_bout=0 and Q<15: R<=sub_d, Q<=Q+1, stay in SUB.
REQ-024 DONE: done=1, quotient=Q, remainder=R; next state IDLE unconditionally.
REQ-025 Latency: SUB lasts Q_final+1 cycles (16 when the cap fires); done rises the cycle after the last SUB cycle.
REQ-026 quotient/remainder are updated only on entry to DONE.

Reset
REQ-027 rst_n low forces IDLE immediately, independent of clk, including mid-operation; the operation in progress is discarded without a done pulse.
REQ-028 Reset values: R, D, Q, quotient, remainder = 4'h0; sub_e, busy, done, div_by_zero = 0.
REQ-029 The first accepted start requires rst_n high at the sampling edge.

Configuration
REQ-030 Macro SUB_DIVIDER_ZERO_CHECK_EN defined: a start accepted with divisor=0 goes IDLE->DONE directly, with no SUB cycle; quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-031 Macro undefined: divisor=0 follows REQ-021..023; the iteration cap ends the operation after 16 SUB cycles with quotient=4'hF, remainder=dividend, div_by_zero=0.

Verification
REQ-032 13/4 -> 4 SUB cycles with sub_e=1; done on the 5th cycle after acceptance; quotient=3, remainder=1, div_by_zero=0.
REQ-033 3/7 -> 1 SUB cycle; quotient=0, remainder=3; done on the 2nd cycle.
REQ-034 15/1 -> 16 SUB cycles; quotient=15, remainder=0; no wrap of Q.
REQ-035 9/0 -> with SUB_DIVIDER_ZERO_CHECK_EN: done next cycle, quotient=F, remainder=9, div_by_zero=1; without it: 16 SUB cycles, quotient=F, remainder=9, div_by_zero=0.
REQ-036 Start 13/4, then pulse start=1 with 2/1 in the 2nd SUB cycle -> ignored; result is 3/1.
REQ-037 Start 14/3, then rst_n=0 in the 2nd SUB cycle -> busy, sub_e, quotient drop to 0 immediately; no done; after release, start 6/2 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/sub_divider_if.sv
// Request/result and external-subtractor signals of the 4-bit repeated-subtraction divider.
// The divider uses the slave modport; the requester and the subtractor model use the master modport.
interface sub_divider_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] sub_a;
    logic [3:0] sub_b;
    logic       sub_e;
    logic [3:0] sub_d;
    logic       sub_bout;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor, sub_d, sub_bout,
        input  sub_a, sub_b, sub_e, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, sub_d, sub_bout,
        output sub_a, sub_b, sub_e, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sub_divider.sv
// 4-bit unsigned divider doing one subtraction per SUB cycle on an external subtractor.
// Optional SUB_DIVIDER_ZERO_CHECK_EN: a zero divisor skips SUB and reports div_by_zero.
module sub_divider (
    input  logic         clk,
    input  logic         rst_n,
    sub_divider_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] r;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] quot;
    logic [3:0] rem;
    logic       dbz;
    logic       sub_end;

    // Stop on a borrow, or once Q is saturated so it never wraps.
    assign sub_end = bus.sub_bout || (q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= 4'h0;
            d     <= 4'h0;
            q     <= 4'h0;
            quot  <= 4'h0;
            rem   <= 4'h0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r   <= bus.dividend;
                        d   <= bus.divisor;
                        q   <= 4'h0;
                        dbz <= 1'b0;
`ifdef SUB_DIVIDER_ZERO_CHECK_EN
                        if (bus.divisor == 4'h0) begin
                            q     <= 4'hF;
                            quot  <= 4'hF;
                            rem   <= bus.dividend;
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SUB;
                        end
`else
                        state <= SUB;
`endif
                    end
                end
                SUB: begin
                    if (sub_end) begin
                        quot  <= q;
                        rem   <= r;
                        state <= DONE;
                    end else begin
                        r <= bus.sub_d;
                        q <= q + 4'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sub_a       = r;
    assign bus.sub_b       = d;
    assign bus.sub_e       = (state == SUB);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quot;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_sub_divider.sv
// Scoreboard bench for sub_divider: a behavioural subtractor, a reference divide model,
// and a negedge monitor comparing each done pulse against the queued expectation.
module tb_sub_divider;
    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         subs;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   subcnt;
    exp_t sb[$];
    exp_t last;

    sub_divider_if bus ();

    sub_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.sub_d    = bus.sub_e ? (bus.sub_a - bus.sub_b) : 4'h0;
    assign bus.sub_bout = bus.sub_e & (bus.sub_a < bus.sub_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   qq;
        int   rr;
`ifdef SUB_DIVIDER_ZERO_CHECK_EN
        if (b == 4'h0) begin
            e.q = 4'hF; e.r = a; e.z = 1'b1; e.subs = 0;
            return e;
        end
`endif
        qq = 0;
        rr = int'(a);
        while (rr >= int'(b) && qq < 15) begin
            rr = rr - int'(b);
            qq++;
        end
        e.q = 4'(qq); e.r = 4'(rr); e.z = 1'b0; e.subs = qq + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            subcnt = 0;
        end else begin
            if (bus.sub_e) begin
                subcnt++;
                chk("sube_busy", 32'(bus.busy), 32'd1);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quot", 32'(bus.quotient), 32'(e.q));
                    chk("rem", 32'(bus.remainder), 32'(e.r));
                    chk("dbz", 32'(bus.div_by_zero), 32'(e.z));
                    chk("sub_cycles", 32'(subcnt), 32'(e.subs));
                    last = e;
                end
                subcnt = 0;
            end
        end
    end

    task automatic start_pulse(input logic [3:0] a, input logic [3:0] b, input bit push);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", 32'(n < 40), 32'd1);
    endtask

    task automatic do_div(input logic [3:0] a, input logic [3:0] b);
        start_pulse(a, b, 1'b1);
        wait_idle();
        @(negedge clk);
        chk("hold_q", 32'(bus.quotient), 32'(last.q));
        chk("hold_r", 32'(bus.remainder), 32'(last.r));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        subcnt       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 4'h0;
        bus.divisor  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_quot", 32'(bus.quotient), 32'd0);
        chk("rst_rem", 32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        chk("rst_sube", 32'(bus.sub_e), 32'd0);
        chk("rst_suba", 32'(bus.sub_a), 32'd0);
        chk("rst_subb", 32'(bus.sub_b), 32'd0);

        // start while reset is held must not be accepted
        bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_accept_in_rst", 32'(bus.busy), 32'd0);

        do_div(4'd13, 4'd4);
        do_div(4'd3, 4'd7);
        do_div(4'd15, 4'd1);
        do_div(4'd9, 4'd0);
        do_div(4'd0, 4'd5);
        do_div(4'd15, 4'd15);

        // start during SUB is ignored
        start_pulse(4'd13, 4'd4, 1'b1);
        start_pulse(4'd2, 4'd1, 1'b0);
        wait_idle();

        // reset mid-operation discards the operation
        start_pulse(4'd14, 4'd3, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_sube", 32'(bus.sub_e), 32'd0);
        chk("mid_rst_quot", 32'(bus.quotient), 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_div(4'd6, 4'd2);

        for (int i = 0; i < 12; i++) begin
            do_div(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
